zx_bus_master: RTL
==================

ZX_BUS_MASTER -- requirements
Module: zx_bus_master

Interface
REQ-001 clk28  in  1  system clock, 28 MHz; all state changes on its rising edge.
REQ-002 rst_n  in  1  reset; asynchronous, active-low.
REQ-003 t_rise  in  1  one-clk28 strobe marking the CPU-clock rising edge (T-state start).
REQ-004 t_fall  in  1  one-clk28 strobe marking the CPU-clock falling edge (mid T-state); never coincident with t_rise.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_op  in  2  operation: 00 mem read, 01 mem write, 10 io read, 11 io write.
REQ-008 cmd_addr  in  16  bus address.
REQ-009 cmd_wdata  in  8  write data.
REQ-010 rsp_valid  out  1  one-clk28 completion pulse.
REQ-011 rsp_rdata  out  8  read data; held until the next read completes.
REQ-012 a  out  16  address bus.
REQ-013 d_o  out  8  data out.
REQ-014 d_oe  out  1  data bus drive enable.
REQ-015 d_i  in  8  data in.
REQ-016 n_mreq, n_iorq, n_rd, n_wr  out  1 each  Z80 bus strobes, active-low.
REQ-017 n_wait  in  1  wait request, active-low.

Function
REQ-018 States: IDLE, START, T1, T2, TW, T3, DONE.
REQ-019 On accept, the block latches op, addr and wdata, then moves to START.
REQ-020 START: waits for t_rise, then drives a=addr and enters T1.
REQ-021 Mem cycle, T1 t_fall: n_mreq=0. For read, n_rd=0. For write, d_o=wdata and d_oe=1.
REQ-022 Mem cycle, the next t_rise enters T2. Mem write, T2 t_fall: n_wr=0.
REQ-023 Mem cycle, T2 t_fall: n_wait is sampled. If n_wait=0, go to TW; otherwise go to T3 at the next t_rise.
REQ-024 IO cycle, T2 t_rise: n_iorq=0, plus n_rd=0 (read) or n_wr=0 (write). For write, d_o and d_oe are set at T1 t_fall.
REQ-025 IO cycle: one TW is always inserted after T2.
REQ-026 TW: n_wait is sampled at each TW t_fall. If 0, TW repeats; if 1, go to T3 at the next t_rise. There is no wait limit.
REQ-027 Mem read: rsp_rdata captures d_i on the T3 t_rise strobe cycle.
REQ-028 IO read: rsp_rdata captures d_i on the T3 t_fall strobe cycle.
REQ-029 T3 t_fall: all strobes (n_mreq, n_iorq, n_rd, n_wr) go to 1, and the block enters DONE.
REQ-030 DONE: rsp_valid=1 for one clk28 cycle.
REQ-031 DONE: d_oe=0 and the block returns to IDLE on the same edge; cmd_ready rises one clk28 later.
REQ-032 After the cycle, a and d_o hold their last values.
REQ-033 A write cycle leaves rsp_rdata unchanged.
REQ-034 cmd_valid is ignored outside IDLE.
REQ-035 Strobe not yet due when in a given state: ignored; t_rise/t_fall pulses in START/IDLE that do not apply are ignored.
REQ-036 n_mreq and n_iorq are never low simultaneously.
REQ-037 n_rd and n_wr are never low simultaneously.

Reset
REQ-038 rst_n=0 forces, asynchronously: state=IDLE, a=0, d_o=0, d_oe=0, n_mreq=n_iorq=n_rd=n_wr=1, rsp_valid=0, rsp_rdata=0, cmd_ready=1.
REQ-039 Reset mid-cycle aborts the cycle and issues no rsp_valid.
REQ-040 After release, the first accept is possible on the first clk28 edge.

Verification
REQ-041 Mem read at 0x4000, d_i=0xA5, n_wait=1 -> n_mreq and n_rd low from T1 fall to T3 fall (2 T-states); rsp_rdata=0xA5; one rsp_valid pulse.
REQ-042 Mem write at 0x5B00, data 0x3C -> d_oe=1 from T1 fall with d_o=0x3C; n_wr low from T2 fall to T3 fall; n_mreq low for 2 T-states.
REQ-043 IO read at 0x00FE, d_i=0x1F -> n_iorq low from T2 rise to T3 fall with exactly one TW; rsp_rdata=0x1F.
REQ-044 Mem read with n_wait=0 for 3 TW t_fall samples -> exactly 3 TW states; strobes held low; completion 3 T-states later than REQ-041.
REQ-045 IO write 0x7FFD, data 0x10, rst_n pulsed low during TW -> all strobes 1 and d_oe=0 immediately; no rsp_valid; cmd_ready=1; a subsequent command completes normally.
REQ-046 Back-to-back commands with cmd_valid held high -> the second is accepted one clk28 after rsp_valid; the strobe invariants REQ-036/REQ-037 hold throughout.

Source files
------------

// File: rtl/zx_bus_master.sv
// Z80-style bus master: turns single read/write commands into T-state
// sequenced memory or I/O bus cycles, timed by CPU-clock edge strobes.
module zx_bus_master (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        t_rise,
  input  logic        t_fall,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] a,
  output logic [7:0]  d_o,
  output logic        d_oe,
  input  logic [7:0]  d_i,
  output logic        n_mreq,
  output logic        n_iorq,
  output logic        n_rd,
  output logic        n_wr,
  input  logic        n_wait
);

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_T1    = 3'd2,
    ST_T2    = 3'd3,
    ST_TW    = 3'd4,
    ST_T3    = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  state_e          state_q;
  logic [OPW-1:0]  op_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            wait_done_q;
  logic            cmd_ready_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic [AW-1:0]   a_q;
  logic [DW-1:0]   d_o_q;
  logic            d_oe_q;
  logic            n_mreq_q;
  logic            n_iorq_q;
  logic            n_rd_q;
  logic            n_wr_q;

  logic is_io;
  logic is_wr;

  assign is_io = op_q[1];
  assign is_wr = op_q[0];

  // Bus cycle sequencer; every output is a register updated here.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_done_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      a_q         <= '0;
      d_o_q       <= '0;
      d_oe_q      <= 1'b0;
      n_mreq_q    <= 1'b1;
      n_iorq_q    <= 1'b1;
      n_rd_q      <= 1'b1;
      n_wr_q      <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q        <= cmd_op;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          if (t_rise) begin
            a_q     <= addr_q;
            state_q <= ST_T1;
          end
        end
        ST_T1: begin
          if (t_fall) begin
            if (!is_io) begin
              n_mreq_q <= 1'b0;
              if (!is_wr) n_rd_q <= 1'b0;
            end
            if (is_wr) begin
              d_o_q  <= wdata_q;
              d_oe_q <= 1'b1;
            end
          end else if (t_rise) begin
            state_q <= ST_T2;
            // I/O strobes start at the T2 rising edge.
            if (is_io) begin
              n_iorq_q <= 1'b0;
              if (is_wr) n_wr_q <= 1'b0;
              else       n_rd_q <= 1'b0;
            end
          end
        end
        ST_T2: begin
          if (t_fall) begin
            if (!is_io && is_wr) n_wr_q <= 1'b0;
            // I/O always takes one wait state; memory only when requested.
            if (is_io || !n_wait) begin
              wait_done_q <= 1'b0;
              state_q     <= ST_TW;
            end
          end else if (t_rise) begin
            state_q <= ST_T3;
            if (!is_wr) rsp_rdata_q <= d_i;
          end
        end
        ST_TW: begin
          if (t_fall) begin
            wait_done_q <= n_wait;
          end else if (t_rise && wait_done_q) begin
            state_q <= ST_T3;
            if (!is_io && !is_wr) rsp_rdata_q <= d_i;
          end
        end
        ST_T3: begin
          if (t_fall) begin
            if (is_io && !is_wr) rsp_rdata_q <= d_i;
            n_mreq_q    <= 1'b1;
            n_iorq_q    <= 1'b1;
            n_rd_q      <= 1'b1;
            n_wr_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          d_oe_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign a         = a_q;
  assign d_o       = d_o_q;
  assign d_oe      = d_oe_q;
  assign n_mreq    = n_mreq_q;
  assign n_iorq    = n_iorq_q;
  assign n_rd      = n_rd_q;
  assign n_wr      = n_wr_q;

endmodule
